// File: rtl/seq_muldiv.sv
// Multi-cycle HI/LO multiply/divide unit: radix-2 shift-add multiplier and restoring divider
// sharing one accumulator, with a start/busy/done handshake.
module seq_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic [1:0]         op_q;
    logic               neg_q;
    logic               rem_neg_q;
    logic               dz_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CNT_W-1:0]   cnt;

    // Operand magnitudes; op[0] selects the signed variants.
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    assign a_neg = op[0] & a[WIDTH-1];
    assign b_neg = op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : '0);
    assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, opb_q};
    // The true difference is below the divisor, so WIDTH bits hold it exactly.
    assign div_diff = div_sh[WIDTH-1:0] - opb_q;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo_fix  = neg_q ? -acc_lo : acc_lo;
    assign rem_fix  = rem_neg_q ? -acc_hi : acc_hi;

    always_ff @(posedge clk) begin
        // NOTE: only control and visible outputs are reset; datapath registers are always
        // loaded in IDLE before use, so resetting them would add muxes for nothing.
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            lo       <= '0;
            hi       <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        if (op[1] && b == '0) begin
                            acc_hi <= a;
                            dz_q   <= 1'b1;
                            state  <= FIX;
                        end else begin
                            dz_q   <= 1'b0;
                            acc_hi <= '0;
                            acc_lo <= op[1] ? a_mag : b_mag;
                            opb_q  <= op[1] ? b_mag : a_mag;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_q[1]) begin
                        acc_hi <= div_ge ? div_diff : div_sh[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= dz_q;
                    state    <= IDLE;
                    if (dz_q) begin
                        lo <= '1;
                        hi <= acc_hi;
                    end else if (op_q[1]) begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_muldiv.sv
// Scoreboard bench for seq_muldiv: expected results are queued at start and checked on done,
// including exact done latency.
module tb_seq_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] lo, hi;

    seq_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .lo(lo), .hi(hi), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
        int           e0;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [63:0]        p;
        logic signed [63:0] px, py;
        logic signed [W-1:0] sx, sy;
        e.dz = 1'b0;
        e.lat = W + 1;
        e.e0 = 0;
        sx = x;
        sy = y;
        case (o)
            2'b00: begin
                p = {32'b0, x} * {32'b0, y};
                e.lo = p[31:0];
                e.hi = p[63:32];
            end
            2'b01: begin
                px = {{32{x[31]}}, x};
                py = {{32{y[31]}}, y};
                p = px * py;
                e.lo = p[31:0];
                e.hi = p[63:32];
            end
            default: begin
                if (y == '0) begin
                    e.lo = '1;
                    e.hi = x;
                    e.dz = 1'b1;
                    e.lat = 1;
                end else if (o == 2'b10) begin
                    e.lo = x / y;
                    e.hi = x % y;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = '0;
                end else begin
                    e.lo = sx / sy;
                    e.hi = sx % sy;
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", done, 0);
            end else begin
                e = sb.pop_front();
                check("lo", lo, e.lo);
                check("hi", hi, e.hi);
                check("div_zero", div_zero, e.dz);
                check("latency", cyc - e.e0, e.lat);
                check("busy_at_done", busy, 0);
            end
        end
    end

    // now=1 drives in the current cycle (used to start in the done cycle).
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit push, input bit now = 1'b0);
        exp_t e;
        if (!now) @(negedge clk);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        if (push) begin
            e = model(o, x, y);
            e.e0 = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
        if (push) check("busy_after_start", busy, 1);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        issue(o, x, y, 1'b1);
        drain();
    endtask

    logic [W-1:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lo", lo, 0);
        check("rst_hi", hi, 0);
        check("rst_dz", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(2'b01, 32'hFFFF_FFFD, 32'h0000_0007);
        run(2'b01, 32'h8000_0000, 32'h8000_0000);
        run(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
        run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'b10, 32'h1234_5678, 32'h0000_0000);
        repeat (3) @(posedge clk);
        #1;
        check("dz_held", div_zero, 1);
        check("hi_held", hi, 32'h1234_5678);
        run(2'b00, 32'd2, 32'd3);

        // Start pulses while busy must be ignored.
        issue(2'b10, 32'd100, 32'd7, 1'b1);
        repeat (5) @(posedge clk);
        issue(2'b00, 32'd5, 32'd5, 1'b0);
        repeat (3) @(posedge clk);
        issue(2'b11, 32'd9, 32'd0, 1'b0);
        drain();

        // Start in the done cycle is accepted.
        issue(2'b00, 32'd1234, 32'd5678, 1'b1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) break;
        end
        issue(2'b11, 32'hFFFF_FF00, 32'd7, 1'b1, 1'b1);
        drain();

        // Reset in the middle of CALC discards the operation.
        issue(2'b01, 32'd7, 32'd9, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_lo", lo, 0);
        check("midrst_hi", hi, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        run(2'b00, 32'd2, 32'd3);

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] x, y;
            x = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            y = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            run(2'($urandom_range(0, 3)), x, y);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
